oneapi_avalon_to_axi_gasket: RTL

Converts an Avalon-ST video source (channels in power-of-two containers, SOP/EOP/empty) into a packed AXI4-Stream video stream (tuser[0]=start-of-frame, tlast=end-of-packet). It sits between the Avalon-ST video pipeline and a oneAPI kernel's AXI4-Stream input. It is the counterpart of the AXI-to-Avalon gasket on the kernel output side.
- 2-entry elastic buffer with registered ready.
- Packet-framing state machine with sticky error flags.

---
 rtl/oneapi_avalon_to_axi_gasket.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/oneapi_avalon_to_axi_gasket.sv
// Avalon-ST video (channels in power-of-two containers) to packed AXI4-Stream video gasket.
// Two-entry elastic buffer with registered ready, plus SOP/EOP framing with sticky error flags.
module oneapi_avalon_to_axi_gasket #(
    parameter int PARALLEL_PIXELS      = 2,
    parameter int BITS_PER_CHANNEL     = 10,
    parameter int CHANNELS             = 3,
    parameter int BITS_PER_CHANNEL_AV  = 16,
    parameter int BITS_PER_PIXEL_AV    = BITS_PER_CHANNEL_AV * CHANNELS,
    parameter int BITS_AV              = BITS_PER_PIXEL_AV * PARALLEL_PIXELS,
    parameter int EMPTY_BITS           = $clog2(BITS_AV / 8),
    parameter int BITS_PER_CHANNEL_AXI = BITS_PER_CHANNEL,
    parameter int BITS_PER_PIXEL_AXI   = ((CHANNELS * BITS_PER_CHANNEL_AXI + 7) / 8) * 8,
    parameter int BITS_AXI             = BITS_PER_PIXEL_AXI * PARALLEL_PIXELS,
    parameter int TUSER_BITS           = (BITS_AXI + 7) / 8,
    parameter int TUSER_FILL           = TUSER_BITS - 2,
    parameter int MASK_OUT             = (1 << BITS_PER_CHANNEL_AXI) - 1
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset_n,
    output logic                  asi_ready,
    input  logic                  asi_valid,
    input  logic [BITS_AV-1:0]    asi_data,
    input  logic                  asi_startofpacket,
    input  logic                  asi_endofpacket,
    input  logic [EMPTY_BITS-1:0] asi_empty,
    input  logic                  axm_tready,
    output logic                  axm_tvalid,
    output logic [BITS_AXI-1:0]   axm_tdata,
    output logic                  axm_tlast,
    output logic [TUSER_BITS-1:0] axm_tuser,
    output logic [1:0]            err_status
);

    typedef enum logic {IDLE, PKT} state_t;

    typedef struct packed {
        logic [BITS_AXI-1:0] data;
        logic                last;
        logic                sof;
    } beat_t;

    state_t     state;
    beat_t      in_beat;
    beat_t      head;
    beat_t      skid;
    logic [1:0] occ;
    logic [1:0] next_occ;
    logic       accept;
    logic       push;
    logic       pop;
    int         valid_bytes;
    logic       unused_data;

    // Container MSBs are discarded by design.
    assign unused_data = ^asi_data;

    assign accept = asi_valid && asi_ready;
    assign push   = accept && (asi_startofpacket || state == PKT);
    assign pop    = axm_tvalid && axm_tready;

    always_comb begin
        in_beat      = '0;
        in_beat.last = asi_endofpacket;
        in_beat.sof  = asi_startofpacket;
        valid_bytes  = BITS_AV / 8 - int'(asi_empty);
        for (int p = 0; p < PARALLEL_PIXELS; p++) begin
            // Only the EOP beat may carry partial pixels; pad bits stay at the zero default.
            if (!asi_endofpacket || (p + 1) * BITS_PER_PIXEL_AV / 8 <= valid_bytes) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    in_beat.data[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL_AXI] =
                        asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL_AXI]
                        & BITS_PER_CHANNEL_AXI'(MASK_OUT);
                end
            end
        end
    end

    always_comb begin
        next_occ = occ;
        if (push && !pop) begin
            next_occ = occ + 2'd1;
        end else if (pop && !push) begin
            next_occ = occ - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            occ        <= 2'd0;
            asi_ready  <= 1'b0;
            axm_tvalid <= 1'b0;
            head       <= '0;
        end else begin
            occ        <= next_occ;
            asi_ready  <= (next_occ < 2'd2);
            axm_tvalid <= (next_occ != 2'd0);
            if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                head <= in_beat;
            end else if (pop && occ == 2'd2) begin
                head <= skid;
            end
        end
    end

    // NOTE: the skid entry is only read when occ says it is valid, so it needs no reset.
    always_ff @(posedge csi_clk) begin
        if (push && occ == 2'd1 && !pop) begin
            skid <= in_beat;
        end
    end

    assign axm_tdata = head.data;
    assign axm_tlast = head.last;
    assign axm_tuser = {{TUSER_FILL{1'b0}}, 1'b0, head.sof};

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state      <= IDLE;
            err_status <= 2'b00;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (asi_startofpacket) begin
                        state <= asi_endofpacket ? IDLE : PKT;
                    end else begin
                        err_status[0] <= 1'b1;
                    end
                end
                PKT: begin
                    // A fresh SOP restarts the frame; the abandoned packet gets no tlast.
                    if (asi_startofpacket) begin
                        err_status[1] <= 1'b1;
                    end
                    if (asi_endofpacket) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
